// File: rtl/exc_dispatch_if.sv
// CP0 exception commit bundle: the dispatch unit drives one registered commit per exception,
// and the CP0 register file consumes it (keyed on a non-zero excepttype).
interface exc_dispatch_if;
    logic [31:0] excepttype;
    logic [31:0] exc_pc;
    logic        exc_delayslot;
    logic [31:0] bad_addr;

    modport master (
        output excepttype,
        output exc_pc,
        output exc_delayslot,
        output bad_addr
    );

    modport slave (
        input excepttype,
        input exc_pc,
        input exc_delayslot,
        input bad_addr
    );
endinterface

// File: rtl/exc_dispatch.sv
// MEM/WB exception detection and dispatch: prioritises faults and interrupts, commits one
// exception to CP0, then flushes the pipeline and redirects fetch to the handler or to EPC.
module exc_dispatch #(
    parameter logic [31:0] HANDLER_PC   = 32'hBFC00380,
    parameter int          FLUSH_CYCLES = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        stall_i,
    input  logic        mem_valid_i,
    input  logic [31:0] mem_pc_i,
    input  logic        mem_in_delayslot_i,
    input  logic [6:0]  mem_flags_i,
    input  logic        mem_ri_i,
    input  logic        mem_adel_if_i,
    input  logic [31:0] mem_addr_i,
    input  logic [31:0] cp0_status_i,
    input  logic [31:0] cp0_cause_i,
    input  logic [31:0] cp0_epc_i,
    input  logic        wb_cp0_we_i,
    input  logic [4:0]  wb_cp0_waddr_i,
    input  logic [31:0] wb_cp0_wdata_i,
    exc_dispatch_if.master cp0,
    output logic        flush_o,
    output logic [31:0] new_pc_o,
    output logic        busy_o
);

    typedef enum logic [1:0] {
        IDLE,
        COMMIT,
        FLUSH
    } state_t;

    localparam logic [2:0]  CNT_INIT  = 3'(FLUSH_CYCLES - 1);
    localparam logic [31:0] CODE_INT  = 32'h01;
    localparam logic [31:0] CODE_ADEL = 32'h04;
    localparam logic [31:0] CODE_ADES = 32'h05;
    localparam logic [31:0] CODE_SYS  = 32'h08;
    localparam logic [31:0] CODE_BP   = 32'h09;
    localparam logic [31:0] CODE_RI   = 32'h0a;
    localparam logic [31:0] CODE_OV   = 32'h0c;
    localparam logic [31:0] CODE_TR   = 32'h0d;
    localparam logic [31:0] CODE_ERET = 32'h0e;

    state_t      state_q;
    logic [2:0]  cnt_q, cnt_d;
    logic [31:0] excepttype_q;
    logic [31:0] exc_pc_q;
    logic        exc_delayslot_q;
    logic [31:0] bad_addr_q, bad_addr_d;
    logic        flush_q;
    logic [31:0] new_pc_q, target_d;
    logic        busy_q;

    logic [31:0] code_d;
    logic        use_bad_d;
    logic        detect;
    logic [31:0] eff_status;
    logic [7:0]  eff_ip;
    logic [31:0] eff_epc;
    logic        int_pend;
    logic        unused_bits;

    // An MTC0 committing in WB this cycle must be visible to the decision made now.
    always_comb begin
        eff_status = cp0_status_i;
        eff_ip     = cp0_cause_i[15:8];
        eff_epc    = cp0_epc_i;
        if (wb_cp0_we_i) begin
            if (wb_cp0_waddr_i == 5'd12) eff_status = wb_cp0_wdata_i;
            if (wb_cp0_waddr_i == 5'd13) eff_ip[1:0] = wb_cp0_wdata_i[9:8];
            if (wb_cp0_waddr_i == 5'd14) eff_epc = wb_cp0_wdata_i;
        end
    end

    assign int_pend = (|(eff_ip & eff_status[15:8])) & eff_status[0] & ~eff_status[1];

    always_comb begin
        code_d     = '0;
        use_bad_d  = 1'b0;
        bad_addr_d = mem_addr_i;
        if (int_pend) begin
            code_d = CODE_INT;
        end else if (mem_adel_if_i) begin
            code_d     = CODE_ADEL;
            use_bad_d  = 1'b1;
            bad_addr_d = mem_pc_i;
        end else if (mem_ri_i) begin
            code_d = CODE_RI;
        end else if (mem_flags_i[0]) begin
            code_d = CODE_SYS;
        end else if (mem_flags_i[1]) begin
            code_d = CODE_BP;
        end else if (mem_flags_i[2]) begin
            code_d = CODE_TR;
        end else if (mem_flags_i[3]) begin
            code_d = CODE_OV;
        end else if (mem_flags_i[4]) begin
            code_d    = CODE_ADEL;
            use_bad_d = 1'b1;
        end else if (mem_flags_i[5]) begin
            code_d    = CODE_ADES;
            use_bad_d = 1'b1;
        end else if (mem_flags_i[6]) begin
            code_d = CODE_ERET;
        end
    end

    assign target_d = (code_d == CODE_ERET) ? eff_epc : HANDLER_PC;
    assign detect   = (state_q == IDLE) && mem_valid_i && !stall_i && (code_d != '0);
    assign cnt_d    = cnt_q - 3'd1;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q         <= IDLE;
            cnt_q           <= '0;
            excepttype_q    <= '0;
            exc_pc_q        <= '0;
            exc_delayslot_q <= 1'b0;
            bad_addr_q      <= '0;
            flush_q         <= 1'b0;
            new_pc_q        <= '0;
            busy_q          <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (detect) begin
                        state_q         <= COMMIT;
                        excepttype_q    <= code_d;
                        exc_pc_q        <= mem_pc_i;
                        exc_delayslot_q <= mem_in_delayslot_i;
                        if (use_bad_d) bad_addr_q <= bad_addr_d;
                        new_pc_q        <= target_d;
                        flush_q         <= 1'b1;
                        busy_q          <= 1'b1;
                    end
                end
                COMMIT: begin
                    excepttype_q <= '0;
                    cnt_q        <= CNT_INIT;
                    if (FLUSH_CYCLES == 1) begin
                        state_q <= IDLE;
                        flush_q <= 1'b0;
                        busy_q  <= 1'b0;
                    end else begin
                        state_q <= FLUSH;
                    end
                end
                FLUSH: begin
                    cnt_q <= cnt_d;
                    if (cnt_d == 3'd0) begin
                        state_q <= IDLE;
                        flush_q <= 1'b0;
                        busy_q  <= 1'b0;
                    end
                end
                default: begin
                    state_q <= IDLE;
                    flush_q <= 1'b0;
                    busy_q  <= 1'b0;
                end
            endcase
        end
    end

    assign cp0.excepttype    = excepttype_q;
    assign cp0.exc_pc        = exc_pc_q;
    assign cp0.exc_delayslot = exc_delayslot_q;
    assign cp0.bad_addr      = bad_addr_q;
    assign flush_o           = flush_q;
    assign new_pc_o          = new_pc_q;
    assign busy_o            = busy_q;

    assign unused_bits = ^{cp0_status_i[31:16], cp0_status_i[7:2],
                           cp0_cause_i[31:16], cp0_cause_i[7:0]};

endmodule

// File: tb/tb_exc_dispatch.sv
// Testbench for exc_dispatch: a cycle-level reference model checked every cycle, plus directed
// scenarios with hand-computed literal expectations.
module tb_exc_dispatch;

    localparam int          FC      = 2;
    localparam logic [31:0] HANDLER = 32'hBFC00380;

    logic        clk = 1'b0;
    logic        rst;
    logic        stall_i;
    logic        mem_valid_i;
    logic [31:0] mem_pc_i;
    logic        mem_in_delayslot_i;
    logic [6:0]  mem_flags_i;
    logic        mem_ri_i;
    logic        mem_adel_if_i;
    logic [31:0] mem_addr_i;
    logic [31:0] cp0_status_i;
    logic [31:0] cp0_cause_i;
    logic [31:0] cp0_epc_i;
    logic        wb_cp0_we_i;
    logic [4:0]  wb_cp0_waddr_i;
    logic [31:0] wb_cp0_wdata_i;
    logic        flush_o;
    logic [31:0] new_pc_o;
    logic        busy_o;

    exc_dispatch_if cp0Bus ();

    exc_dispatch #(.HANDLER_PC(HANDLER), .FLUSH_CYCLES(FC)) dut (
        .clk               (clk),
        .rst               (rst),
        .stall_i           (stall_i),
        .mem_valid_i       (mem_valid_i),
        .mem_pc_i          (mem_pc_i),
        .mem_in_delayslot_i(mem_in_delayslot_i),
        .mem_flags_i       (mem_flags_i),
        .mem_ri_i          (mem_ri_i),
        .mem_adel_if_i     (mem_adel_if_i),
        .mem_addr_i        (mem_addr_i),
        .cp0_status_i      (cp0_status_i),
        .cp0_cause_i       (cp0_cause_i),
        .cp0_epc_i         (cp0_epc_i),
        .wb_cp0_we_i       (wb_cp0_we_i),
        .wb_cp0_waddr_i    (wb_cp0_waddr_i),
        .wb_cp0_wdata_i    (wb_cp0_wdata_i),
        .cp0               (cp0Bus),
        .flush_o           (flush_o),
        .new_pc_o          (new_pc_o),
        .busy_o            (busy_o)
    );

    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;
    logic cmpEn = 1'b0;

    // Reference model: expected outputs after each edge; mLeft counts flush cycles still shown.
    logic [31:0] eExc, ePc, eBad, eNewPc;
    logic        eDs, eFlush, eBusy;
    int          mLeft;

    function automatic void mdlPredict(output logic hit, output logic [31:0] code,
                                       output logic useBad, output logic [31:0] badVal,
                                       output logic [31:0] target);
        logic [31:0] st;
        logic [31:0] ca;
        logic [31:0] ep;
        logic        intr;
        logic        conds [10];
        int          codes [10] = '{1, 4, 10, 8, 9, 13, 12, 4, 5, 14};
        st = cp0_status_i;
        ca = cp0_cause_i;
        ep = cp0_epc_i;
        if (wb_cp0_we_i && wb_cp0_waddr_i == 5'd12) st = wb_cp0_wdata_i;
        if (wb_cp0_we_i && wb_cp0_waddr_i == 5'd13) ca[9:8] = wb_cp0_wdata_i[9:8];
        if (wb_cp0_we_i && wb_cp0_waddr_i == 5'd14) ep = wb_cp0_wdata_i;
        intr = ((ca[15:8] & st[15:8]) != 8'h00) && st[0] && !st[1];
        conds[0] = intr;
        conds[1] = mem_adel_if_i;
        conds[2] = mem_ri_i;
        for (int k = 0; k < 7; k++) conds[3 + k] = mem_flags_i[k];
        hit = 1'b0; code = '0; useBad = 1'b0; badVal = '0;
        for (int k = 0; k < 10; k++) begin
            if (!hit && conds[k]) begin
                hit    = 1'b1;
                code   = 32'(codes[k]);
                useBad = (k == 1) || (k == 7) || (k == 8);
                badVal = (k == 1) ? mem_pc_i : mem_addr_i;
            end
        end
        target = (code == 32'h0e) ? ep : HANDLER;
    endfunction

    always @(posedge clk or negedge rst) begin
        logic        hit, useBad;
        logic [31:0] code, badVal, target;
        if (!rst) begin
            eExc = '0; ePc = '0; eBad = '0; eNewPc = '0;
            eDs = 1'b0; eFlush = 1'b0; eBusy = 1'b0; mLeft = 0;
        end else if (mLeft > 0) begin
            mLeft = mLeft - 1;
            eExc  = '0;
            if (mLeft == 0) begin
                eFlush = 1'b0;
                eBusy  = 1'b0;
            end
        end else if (mem_valid_i && !stall_i) begin
            mdlPredict(hit, code, useBad, badVal, target);
            if (hit) begin
                eExc   = code;
                ePc    = mem_pc_i;
                eDs    = mem_in_delayslot_i;
                if (useBad) eBad = badVal;
                eNewPc = target;
                eFlush = 1'b1;
                eBusy  = 1'b1;
                mLeft  = FC;
            end
        end
    end

    // Every-cycle comparison of the whole output set against the model.
    always @(negedge clk) begin
        if (cmpEn) begin
            checks++;
            if ({cp0Bus.excepttype, cp0Bus.exc_pc, cp0Bus.exc_delayslot, cp0Bus.bad_addr,
                 flush_o, new_pc_o, busy_o} !==
                {eExc, ePc, eDs, eBad, eFlush, eNewPc, eBusy}) begin
                errors++;
                $display("[TB] FAIL model-compare t=%0t got/expected exc=%h/%h pc=%h/%h ds=%b/%b bad=%h/%h flush=%b/%b npc=%h/%h busy=%b/%b",
                         $time, cp0Bus.excepttype, eExc, cp0Bus.exc_pc, ePc, cp0Bus.exc_delayslot, eDs,
                         cp0Bus.bad_addr, eBad, flush_o, eFlush, new_pc_o, eNewPc, busy_o, eBusy);
            end
        end
    end

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic idleInputs();
        stall_i = 1'b0; mem_valid_i = 1'b0; mem_pc_i = '0; mem_in_delayslot_i = 1'b0;
        mem_flags_i = '0; mem_ri_i = 1'b0; mem_adel_if_i = 1'b0; mem_addr_i = '0;
        wb_cp0_we_i = 1'b0; wb_cp0_waddr_i = '0; wb_cp0_wdata_i = '0;
    endtask

    // Presents one MEM instruction for one edge; returns at the following negedge.
    task automatic applyStimulus(input logic [31:0] pc, input logic ds, input logic [6:0] fl,
                                 input logic ri, input logic adelIf, input logic [31:0] addr);
        mem_valid_i = 1'b1; mem_pc_i = pc; mem_in_delayslot_i = ds;
        mem_flags_i = fl; mem_ri_i = ri; mem_adel_if_i = adelIf; mem_addr_i = addr;
        @(negedge clk);
        mem_valid_i = 1'b0; mem_flags_i = '0; mem_ri_i = 1'b0; mem_adel_if_i = 1'b0;
        wb_cp0_we_i = 1'b0;
    endtask

    task automatic waitCycles(input int n);
        repeat (n) @(negedge clk);
    endtask

    initial begin
        rst = 1'b0;
        idleInputs();
        cp0_status_i = '0; cp0_cause_i = '0; cp0_epc_i = '0;
        waitCycles(2);
        checkOutput("reset excepttype", cp0Bus.excepttype, 32'h0);
        checkOutput("reset flush", {31'b0, flush_o}, 32'h0);
        checkOutput("reset busy", {31'b0, busy_o}, 32'h0);
        checkOutput("reset new_pc", new_pc_o, 32'h0);
        rst = 1'b1;
        cmpEn = 1'b1;
        waitCycles(1);

        $display("[TB] syscall dispatch");
        applyStimulus(32'hBFC00100, 1'b0, 7'b0000001, 1'b0, 1'b0, 32'h0);
        checkOutput("sys excepttype", cp0Bus.excepttype, 32'h08);
        checkOutput("sys exc_pc", cp0Bus.exc_pc, 32'hBFC00100);
        checkOutput("sys delayslot", {31'b0, cp0Bus.exc_delayslot}, 32'h0);
        checkOutput("sys flush c1", {31'b0, flush_o}, 32'h1);
        checkOutput("sys new_pc", new_pc_o, 32'hBFC00380);
        waitCycles(1);
        checkOutput("sys excepttype c2", cp0Bus.excepttype, 32'h0);
        checkOutput("sys flush c2", {31'b0, flush_o}, 32'h1);
        waitCycles(1);
        checkOutput("sys flush c3", {31'b0, flush_o}, 32'h0);

        $display("[TB] interrupt");
        cp0_status_i = 32'h0000FF01; cp0_cause_i = 32'h00000400;
        applyStimulus(32'h80000010, 1'b1, 7'b0, 1'b0, 1'b0, 32'h0);
        checkOutput("int excepttype", cp0Bus.excepttype, 32'h01);
        checkOutput("int delayslot", {31'b0, cp0Bus.exc_delayslot}, 32'h1);
        checkOutput("int exc_pc", cp0Bus.exc_pc, 32'h80000010);
        waitCycles(2);
        cp0_status_i = 32'h0000FF03;
        applyStimulus(32'h80000010, 1'b1, 7'b0, 1'b0, 1'b0, 32'h0);
        checkOutput("int exl masked", cp0Bus.excepttype, 32'h0);
        checkOutput("int exl no flush", {31'b0, flush_o}, 32'h0);
        cp0_status_i = 32'h0000FF01;
        wb_cp0_we_i = 1'b1; wb_cp0_waddr_i = 5'd12; wb_cp0_wdata_i = 32'h0000FF00;
        applyStimulus(32'h80000014, 1'b0, 7'b0, 1'b0, 1'b0, 32'h0);
        checkOutput("int mtc0 ie clear", cp0Bus.excepttype, 32'h0);
        cp0_cause_i = 32'h0;
        wb_cp0_we_i = 1'b1; wb_cp0_waddr_i = 5'd13; wb_cp0_wdata_i = 32'h00000100;
        applyStimulus(32'h80000018, 1'b0, 7'b0, 1'b0, 1'b0, 32'h0);
        checkOutput("int cause bypass", cp0Bus.excepttype, 32'h01);
        waitCycles(2);
        cp0_status_i = '0;

        $display("[TB] priority and bad address");
        applyStimulus(32'h80000020, 1'b0, 7'b0011000, 1'b0, 1'b0, 32'h80000003);
        checkOutput("ov over adel", cp0Bus.excepttype, 32'h0c);
        checkOutput("ov bad_addr held", cp0Bus.bad_addr, 32'h0);
        waitCycles(2);
        applyStimulus(32'h80000024, 1'b0, 7'b0010000, 1'b0, 1'b0, 32'h80000003);
        checkOutput("adel excepttype", cp0Bus.excepttype, 32'h04);
        checkOutput("adel bad_addr", cp0Bus.bad_addr, 32'h80000003);
        waitCycles(2);
        applyStimulus(32'h80000044, 1'b0, 7'b0000001, 1'b1, 1'b1, 32'hDEAD0000);
        checkOutput("adel_if excepttype", cp0Bus.excepttype, 32'h04);
        checkOutput("adel_if bad_addr", cp0Bus.bad_addr, 32'h80000044);
        waitCycles(2);
        applyStimulus(32'h80000048, 1'b0, 7'b0100001, 1'b1, 1'b0, 32'h00000011);
        checkOutput("ri over sys", cp0Bus.excepttype, 32'h0a);
        checkOutput("ri bad_addr held", cp0Bus.bad_addr, 32'h80000044);
        waitCycles(2);
        applyStimulus(32'h8000004C, 1'b0, 7'b0100000, 1'b0, 1'b0, 32'h00000022);
        checkOutput("ades excepttype", cp0Bus.excepttype, 32'h05);
        checkOutput("ades bad_addr", cp0Bus.bad_addr, 32'h00000022);
        waitCycles(2);

        $display("[TB] eret with EPC bypass");
        cp0_epc_i = 32'h00001000;
        wb_cp0_we_i = 1'b1; wb_cp0_waddr_i = 5'd14; wb_cp0_wdata_i = 32'h00002000;
        applyStimulus(32'h80000050, 1'b0, 7'b1000000, 1'b0, 1'b0, 32'h0);
        checkOutput("eret excepttype", cp0Bus.excepttype, 32'h0e);
        checkOutput("eret new_pc", new_pc_o, 32'h00002000);
        waitCycles(2);

        $display("[TB] stall then ignored syscall in flush");
        stall_i = 1'b1; mem_valid_i = 1'b1; mem_pc_i = 32'hBFC00200; mem_flags_i = 7'b0000001;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            checkOutput("stall no commit", cp0Bus.excepttype, 32'h0);
            checkOutput("stall no flush", {31'b0, flush_o}, 32'h0);
        end
        stall_i = 1'b0;
        @(negedge clk);
        checkOutput("unstall excepttype", cp0Bus.excepttype, 32'h08);
        checkOutput("unstall exc_pc", cp0Bus.exc_pc, 32'hBFC00200);
        mem_pc_i = 32'hBFC00300;
        @(negedge clk);
        checkOutput("flush ignores sys", cp0Bus.excepttype, 32'h0);
        checkOutput("flush keeps exc_pc", cp0Bus.exc_pc, 32'hBFC00200);
        @(negedge clk);
        mem_valid_i = 1'b0; mem_flags_i = '0;
        checkOutput("after flush idle", {31'b0, flush_o}, 32'h0);
        @(negedge clk);
        checkOutput("second sys dropped", cp0Bus.excepttype, 32'h0);

        $display("[TB] reset during flush");
        applyStimulus(32'hBFC00400, 1'b0, 7'b0000001, 1'b0, 1'b0, 32'h0);
        @(negedge clk);
        #2 rst = 1'b0;
        #1;
        checkOutput("rst flush", {31'b0, flush_o}, 32'h0);
        checkOutput("rst excepttype", cp0Bus.excepttype, 32'h0);
        checkOutput("rst busy", {31'b0, busy_o}, 32'h0);
        checkOutput("rst exc_pc", cp0Bus.exc_pc, 32'h0);
        @(negedge clk);
        #2 rst = 1'b1;
        @(negedge clk);
        applyStimulus(32'hBFC00500, 1'b0, 7'b0000001, 1'b0, 1'b0, 32'h0);
        checkOutput("post-rst excepttype", cp0Bus.excepttype, 32'h08);
        checkOutput("post-rst exc_pc", cp0Bus.exc_pc, 32'hBFC00500);
        checkOutput("post-rst flush", {31'b0, flush_o}, 32'h1);
        waitCycles(3);

        cmpEn = 1'b0;
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
